// File: rtl/layer_sequencer_if.sv
// Bus bundle between the layer sequencer (master) and the convolution datapath (slave).
// Carries the layer handshake inputs and every datapath strobe and address.
interface layer_sequencer_if #(
  parameter int ADDR_WIDTH_IA  = 11,
  parameter int WTS_ADDR_WIDTH = 6,
  parameter int RAM_ADDR_WIDTH = 5
);
  logic                      start;
  logic                      pool_en;
  logic [ADDR_WIDTH_IA-1:0]  base_ia;
  logic                      abort;
  logic                      pool_done;
  logic                      enable_wts_rom;
  logic [WTS_ADDR_WIDTH-1:0] wts_bram_addr;
  logic                      wts_rf_enable;
  logic                      addr_bram_enable;
  logic [ADDR_WIDTH_IA-1:0]  address_ia;
  logic                      addr_rf_enable;
  logic                      accumulator_reset;
  logic                      adder_enable;
  logic                      accumulator_enable;
  logic [RAM_ADDR_WIDTH-1:0] ram_address;
  logic                      ram_we;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, pool_en, base_ia, abort, pool_done,
    output enable_wts_rom, wts_bram_addr, wts_rf_enable,
           addr_bram_enable, address_ia, addr_rf_enable,
           accumulator_reset, adder_enable, accumulator_enable,
           ram_address, ram_we, busy, done
  );

  modport slave (
    output start, pool_en, base_ia, abort, pool_done,
    input  enable_wts_rom, wts_bram_addr, wts_rf_enable,
           addr_bram_enable, address_ia, addr_rf_enable,
           accumulator_reset, adder_enable, accumulator_enable,
           ram_address, ram_we, busy, done
  );
endinterface

// File: rtl/layer_sequencer.sv
// Per-layer control sequencer: walks output pixels, channels and taps, driving
// weight/activation fetches, MAC steps, optional pooling wait and output writes.
module layer_sequencer #(
  parameter int ADDR_WIDTH_IA  = 11,
  parameter int WTS_ADDR_WIDTH = 6,
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int NUM_CH         = 4,
  parameter int TAPS           = 9,
  parameter int NUM_OUT        = 8
) (
  input logic               clock,
  input logic               reset,
  layer_sequencer_if.master bus
);
  localparam int T_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int C_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int O_W = RAM_ADDR_WIDTH;
  localparam logic [T_W-1:0] T_LAST = T_W'(TAPS - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(NUM_CH - 1);
  localparam logic [O_W-1:0] O_LAST = O_W'(NUM_OUT - 1);
  localparam logic [WTS_ADDR_WIDTH-1:0] W_TAPS = WTS_ADDR_WIDTH'(TAPS);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ACC_CLR   = 4'd1,
    LOAD      = 4'd2,
    FETCH     = 4'd3,
    DRAIN     = 4'd4,
    MAC       = 4'd5,
    POOL_WAIT = 4'd6,
    WRITE     = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t                   state_r, state_s;
  logic [T_W-1:0]           t_r, t_s;
  logic [C_W-1:0]           c_r, c_s;
  logic [O_W-1:0]           o_r, o_s;
  logic [ADDR_WIDTH_IA-1:0] ptr_r, ptr_s;
  logic                     pool_r, pool_s;

  logic                      en_wts_r, en_wts_s, wts_rf_r;
  logic [WTS_ADDR_WIDTH-1:0] wts_addr_r, wts_addr_s;
  logic                      en_addr_r, en_addr_s, addr_rf_r;
  logic [ADDR_WIDTH_IA-1:0]  address_r, address_s;
  logic                      acc_rst_r, acc_rst_s;
  logic                      mac_r, mac_s;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_r, ram_addr_s;
  logic                      ram_we_r, ram_we_s;
  logic                      busy_r, busy_s;
  logic                      done_r, done_s;

  // Next-state and counter update; abort overrides every state, including a start in IDLE.
  always_comb begin
    state_s = state_r;
    t_s     = t_r;
    c_s     = c_r;
    o_s     = o_r;
    ptr_s   = ptr_r;
    pool_s  = pool_r;
    if (bus.abort) begin
      state_s = IDLE;
      t_s     = '0;
      c_s     = '0;
      o_s     = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_s = ACC_CLR;
            pool_s  = bus.pool_en;
            ptr_s   = bus.base_ia;
            t_s     = '0;
            c_s     = '0;
            o_s     = '0;
          end else begin
            state_s = IDLE;
          end
        end
        ACC_CLR: begin
          c_s     = '0;
          t_s     = '0;
          state_s = LOAD;
        end
        LOAD: begin
          if (t_r == T_LAST) begin
            t_s     = '0;
            state_s = FETCH;
          end else begin
            t_s = t_r + T_W'(1'b1);
          end
        end
        FETCH: begin
          // The activation pointer free-runs across pixels and wraps naturally.
          ptr_s = ptr_r + ADDR_WIDTH_IA'(1'b1);
          if (t_r == T_LAST) begin
            t_s     = '0;
            state_s = DRAIN;
          end else begin
            t_s = t_r + T_W'(1'b1);
          end
        end
        DRAIN: state_s = MAC;
        MAC: begin
          if (c_r < C_LAST) begin
            c_s     = c_r + C_W'(1'b1);
            state_s = LOAD;
          end else if (pool_r) begin
            state_s = POOL_WAIT;
          end else begin
            state_s = WRITE;
          end
        end
        POOL_WAIT: begin
          if (bus.pool_done) begin
            state_s = WRITE;
          end else begin
            state_s = POOL_WAIT;
          end
        end
        WRITE: begin
          if (o_r < O_LAST) begin
            o_s     = o_r + O_W'(1'b1);
            state_s = ACC_CLR;
          end else begin
            state_s = DONE;
          end
        end
        DONE: state_s = IDLE;
        default: begin
          state_s = IDLE;
          t_s     = '0;
          c_s     = '0;
          o_s     = '0;
        end
      endcase
    end
  end

  // Output values for the state about to be entered, so the registers line up with it.
  always_comb begin
    en_wts_s  = (state_s == LOAD);
    en_addr_s = (state_s == FETCH);
    acc_rst_s = (state_s == ACC_CLR);
    mac_s     = (state_s == MAC);
    ram_we_s  = (state_s == WRITE);
    busy_s    = (state_s != IDLE);
    done_s    = (state_s == DONE);
    if (state_s == LOAD) begin
      wts_addr_s = WTS_ADDR_WIDTH'(c_s) * W_TAPS + WTS_ADDR_WIDTH'(t_s);
    end else begin
      wts_addr_s = wts_addr_r;
    end
    if (state_s == FETCH) begin
      address_s = ptr_s;
    end else begin
      address_s = address_r;
    end
    if (state_s == WRITE) begin
      ram_addr_s = o_s;
    end else begin
      ram_addr_s = ram_addr_r;
    end
  end

  // State, loop counters, activation pointer and latched pooling mode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      t_r     <= '0;
      c_r     <= '0;
      o_r     <= '0;
      ptr_r   <= '0;
      pool_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      t_r     <= t_s;
      c_r     <= c_s;
      o_r     <= o_s;
      ptr_r   <= ptr_s;
      pool_r  <= pool_s;
    end
  end

  // Registered outputs; rf enables trail the BRAM enables by the one-cycle read latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_wts_r   <= 1'b0;
      wts_addr_r <= '0;
      wts_rf_r   <= 1'b0;
      en_addr_r  <= 1'b0;
      address_r  <= '0;
      addr_rf_r  <= 1'b0;
      acc_rst_r  <= 1'b0;
      mac_r      <= 1'b0;
      ram_addr_r <= '0;
      ram_we_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      en_wts_r   <= en_wts_s;
      wts_addr_r <= wts_addr_s;
      wts_rf_r   <= bus.abort ? 1'b0 : en_wts_r;
      en_addr_r  <= en_addr_s;
      address_r  <= address_s;
      addr_rf_r  <= bus.abort ? 1'b0 : en_addr_r;
      acc_rst_r  <= acc_rst_s;
      mac_r      <= mac_s;
      ram_addr_r <= ram_addr_s;
      ram_we_r   <= ram_we_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign bus.enable_wts_rom     = en_wts_r;
  assign bus.wts_bram_addr      = wts_addr_r;
  assign bus.wts_rf_enable      = wts_rf_r;
  assign bus.addr_bram_enable   = en_addr_r;
  assign bus.address_ia         = address_r;
  assign bus.addr_rf_enable     = addr_rf_r;
  assign bus.accumulator_reset  = acc_rst_r;
  assign bus.adder_enable       = mac_r;
  assign bus.accumulator_enable = mac_r;
  assign bus.ram_address        = ram_addr_r;
  assign bus.ram_we             = ram_we_r;
  assign bus.busy               = busy_r;
  assign bus.done               = done_r;
endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: stimulus queues expected writes and
// per-layer totals, a negedge monitor pops and compares them as the DUT emits them.
module tb_layer_sequencer;
  localparam int AW  = 11;
  localparam int WW  = 6;
  localparam int RW  = 5;
  localparam int NCH = 4;
  localparam int TP  = 9;
  localparam int NO  = 8;

  typedef struct {
    int busy_len;
    int nrst;
    int nacc;
  } layer_exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  bit   pool_mode = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int         we_q[$];
  layer_exp_t done_q[$];

  always #5 clock = ~clock;

  layer_sequencer_if #(.ADDR_WIDTH_IA(AW), .WTS_ADDR_WIDTH(WW), .RAM_ADDR_WIDTH(RW)) bus ();

  layer_sequencer #(
    .ADDR_WIDTH_IA(AW), .WTS_ADDR_WIDTH(WW), .RAM_ADDR_WIDTH(RW),
    .NUM_CH(NCH), .TAPS(TP), .NUM_OUT(NO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_layer(input int n_we, input bit with_done, input int blen);
    layer_exp_t e;
    for (int i = 0; i < n_we; i++) we_q.push_back(i);
    if (with_done) begin
      e.busy_len = blen;
      e.nrst     = NO;
      e.nacc     = NO * NCH;
      done_q.push_back(e);
    end
  endtask

  task automatic start_layer(input logic [AW-1:0] base, input bit pen);
    @(posedge clock);
    #1 bus.base_ia = base; bus.pool_en = pen; bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0; bus.pool_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (bus.done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, int'(seen), 1);
  endtask

  // Monitor / scoreboard
  initial begin
    int         busy_len, nrst, nacc, wexp;
    logic [AW-1:0] ptr_exp;
    logic       prev_wen, prev_aen, prev_abort, prev_busy;
    layer_exp_t e;
    busy_len = 0; nrst = 0; nacc = 0; wexp = 0; ptr_exp = '0;
    prev_wen = 1'b0; prev_aen = 1'b0; prev_abort = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        busy_len = 0; nrst = 0; nacc = 0; wexp = 0;
        prev_wen = 1'b0; prev_aen = 1'b0; prev_abort = 1'b0; prev_busy = 1'b0;
      end else begin
        chk("wts_rf_delay", int'(bus.wts_rf_enable), int'(prev_wen & ~prev_abort));
        chk("addr_rf_delay", int'(bus.addr_rf_enable), int'(prev_aen & ~prev_abort));
        if (!bus.busy) begin
          busy_len = 0; nrst = 0; nacc = 0;
        end else begin
          if (!prev_busy) ptr_exp = bus.base_ia;
          busy_len++;
          if (bus.accumulator_reset) begin
            nrst++;
            wexp = 0;
          end
          if (bus.accumulator_enable) nacc++;
          if (bus.enable_wts_rom) begin
            chk("wts_bram_addr", int'(bus.wts_bram_addr), wexp);
            wexp++;
          end
          if (bus.addr_bram_enable) begin
            chk("address_ia", int'(bus.address_ia), int'(ptr_exp));
            ptr_exp = ptr_exp + 11'd1;
          end
          if (bus.ram_we) begin
            chk("ram_we_expected", int'(we_q.size() > 0), 1);
            if (we_q.size() > 0) chk("ram_address", int'(bus.ram_address), we_q.pop_front());
          end
          if (bus.done) begin
            chk("done_expected", int'(done_q.size() > 0), 1);
            if (done_q.size() > 0) begin
              e = done_q.pop_front();
              chk("busy_cycles", busy_len, e.busy_len);
              chk("acc_reset_pulses", nrst, e.nrst);
              chk("acc_enable_pulses", nacc, e.nacc);
            end
          end
        end
        prev_wen   = bus.enable_wts_rom;
        prev_aen   = bus.addr_bram_enable;
        prev_abort = bus.abort;
        prev_busy  = bus.busy;
      end
    end
  end

  // Pooling-unit responder: pool_done 5 cycles into each POOL_WAIT, plus one stray pulse in FETCH
  initial begin
    int macs;
    bit poked;
    macs = 0;
    poked = 1'b0;
    bus.pool_done = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset || !bus.busy) begin
        macs = 0;
        poked = 1'b0;
      end else if (pool_mode) begin
        if (bus.addr_bram_enable && !poked) begin
          poked = 1'b1;
          @(posedge clock); #1 bus.pool_done = 1'b1;
          @(posedge clock); #1 bus.pool_done = 1'b0;
        end else if (bus.accumulator_enable) begin
          macs++;
          if (macs % NCH == 0) begin
            repeat (5) @(posedge clock);
            #1 bus.pool_done = 1'b1;
            @(posedge clock); #1 bus.pool_done = 1'b0;
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int nwe;
    bit found, any_done;
    bus.start = 1'b0; bus.pool_en = 1'b0; bus.base_ia = '0; bus.abort = 1'b0;

    repeat (2) @(negedge clock);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_address_ia", int'(bus.address_ia), 0);
    chk("rst_wts_addr", int'(bus.wts_bram_addr), 0);
    chk("rst_ram_address", int'(bus.ram_address), 0);
    chk("rst_strobes", int'({bus.enable_wts_rom, bus.addr_bram_enable, bus.accumulator_reset,
                             bus.accumulator_enable, bus.ram_we, bus.wts_rf_enable}), 0);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);

    // Default layer with start-to-ACC_CLR latency
    push_layer(NO, 1'b1, 657);
    @(posedge clock);
    #1 bus.base_ia = 11'd0; bus.start = 1'b1;
    @(negedge clock);
    chk("busy_before_start_edge", int'(bus.busy), 0);
    @(posedge clock);
    #1 bus.start = 1'b0;
    @(negedge clock);
    chk("acc_clr_after_start", int'(bus.accumulator_reset), 1);
    chk("busy_after_start", int'(bus.busy), 1);
    wait_done("default", 800);
    @(negedge clock);
    chk("idle_busy", int'(bus.busy), 0);
    chk("final_address_ia", int'(bus.address_ia), 287);
    chk("held_wts_addr", int'(bus.wts_bram_addr), 35);
    chk("held_ram_address", int'(bus.ram_address), 7);

    // Pooling layer: 87 cycles per pixel, stray pool_done in FETCH ignored
    pool_mode = 1'b1;
    push_layer(NO, 1'b1, 697);
    start_layer(11'd0, 1'b1);
    wait_done("pool", 900);
    pool_mode = 1'b0;

    // Activation address wrap-around
    push_layer(NO, 1'b1, 657);
    start_layer(11'd2040, 1'b0);
    wait_done("wrap", 800);
    @(negedge clock);
    chk("wrap_final_address_ia", int'(bus.address_ia), 279);

    // Abort during the third pixel's FETCH, then a clean restart
    push_layer(2, 1'b0, 0);
    start_layer(11'd100, 1'b0);
    nwe = 0;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clock);
      if (bus.ram_we) nwe++;
      if (nwe >= 2 && bus.addr_bram_enable) found = 1'b1;
    end
    chk("abort_window_found", int'(found), 1);
    @(posedge clock);
    #1 bus.abort = 1'b1;
    @(posedge clock);
    #1 bus.abort = 1'b0;
    @(negedge clock);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_strobes", int'({bus.enable_wts_rom, bus.addr_bram_enable, bus.accumulator_reset,
                               bus.accumulator_enable, bus.ram_we, bus.wts_rf_enable,
                               bus.addr_rf_enable}), 0);
    any_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.done || bus.busy) any_done = 1'b1;
    end
    chk("abort_no_done", int'(any_done), 0);
    push_layer(NO, 1'b1, 657);
    start_layer(11'd100, 1'b0);
    wait_done("restart", 800);
    @(negedge clock);
    chk("restart_final_address_ia", int'(bus.address_ia), 387);

    // Asynchronous reset while in MAC
    start_layer(11'd0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (bus.accumulator_enable) found = 1'b1;
    end
    chk("mac_reached", int'(found), 1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_mac", int'({bus.adder_enable, bus.accumulator_enable}), 0);
    chk("async_rst_address_ia", int'(bus.address_ia), 0);
    chk("async_rst_wts_addr", int'(bus.wts_bram_addr), 0);
    @(negedge clock);
    #2 reset = 1'b1;

    // Start held high: second layer after exactly one idle cycle
    push_layer(NO, 1'b1, 657);
    push_layer(NO, 1'b1, 657);
    @(posedge clock);
    #1 bus.base_ia = 11'd0; bus.start = 1'b1;
    wait_done("b2b_first", 800);
    @(negedge clock);
    chk("b2b_idle_gap", int'(bus.busy), 0);
    @(negedge clock);
    chk("b2b_restart_acc_clr", int'(bus.accumulator_reset), 1);
    @(posedge clock);
    #1 bus.start = 1'b0;
    wait_done("b2b_second", 800);

    repeat (3) @(negedge clock);
    chk("we_queue_drained", we_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
